// File: rtl/siphash_pkg.sv
// Shared constants for the SipHash message front end: word geometry,
// length-byte position and the padder FSM state encodings.
package siphash_pkg;

    localparam int WORD_W  = 64;
    localparam int LEN_MSB = 63;
    localparam int LEN_LSB = 56;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INIT     = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_FIN      = 3'd3;
    localparam logic [2:0] ST_WAIT_FIN = 3'd4;

    // Final block: leftover bytes in the low lanes, length mod 256 in the top byte.
    function automatic logic [WORD_W-1:0] tail_word(input logic [WORD_W-1:0] asm_word,
                                                    input logic [7:0]        len_byte);
        logic [WORD_W-1:0] w;
        w = asm_word;
        w[LEN_MSB:LEN_LSB] = asm_word[LEN_MSB:LEN_LSB] | len_byte;
        return w;
    endfunction

endpackage

// File: rtl/siphash_byte_packer.sv
// Little-endian byte-to-word packer with a one-word pending buffer and the
// SipHash tail-word build. The pending slot counts as free in the cycle it is
// being taken, so a full assembly word or the tail can refill it back-to-back.
module siphash_byte_packer
    import siphash_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_accept,
    input  logic [7:0]        byte_in,
    input  logic              set_last,
    input  logic              pend_take,
    output logic              asm_full,
    output logic              last_seen,
    output logic              tail_built,
    output logic              pend_valid,
    output logic [WORD_W-1:0] pend_word
);

    logic [WORD_W-1:0] asm_q, asm_d;
    logic [3:0]        asm_cnt_q, asm_cnt_d;
    logic [7:0]        len_q, len_d;
    logic [WORD_W-1:0] pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic              last_seen_q, last_seen_d;
    logic              tail_built_q, tail_built_d;

    logic              pend_free;
    logic              do_transfer;
    logic              do_tail;

    // Next-state for assembly, length, pending buffer and end-of-message flags.
    always_comb begin
        asm_d        = asm_q;
        asm_cnt_d    = asm_cnt_q;
        len_d        = len_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        last_seen_d  = last_seen_q;
        tail_built_d = tail_built_q;

        pend_free   = !pend_valid_q || pend_take;
        do_transfer = (asm_cnt_q == 4'd8) && pend_free;
        do_tail     = last_seen_q && (asm_cnt_q < 4'd8) && pend_free && !tail_built_q;

        if (pend_take) begin
            pend_valid_d = 1'b0;
        end

        if (byte_accept && (asm_cnt_q < 4'd8) && !last_seen_q) begin
            asm_d[{asm_cnt_q[2:0], 3'b000} +: 8] = byte_in;
            asm_cnt_d = asm_cnt_q + 4'd1;
            len_d     = len_q + 8'd1;
        end

        if (set_last) begin
            last_seen_d = 1'b1;
        end

        // A refill wins over the take-clear above.
        if (do_transfer) begin
            pend_d       = asm_q;
            pend_valid_d = 1'b1;
            asm_d        = '0;
            asm_cnt_d    = 4'd0;
        end else if (do_tail) begin
            pend_d       = tail_word(asm_q, len_q);
            pend_valid_d = 1'b1;
            tail_built_d = 1'b1;
        end

        if (clear) begin
            asm_d        = '0;
            asm_cnt_d    = 4'd0;
            len_d        = 8'd0;
            pend_d       = '0;
            pend_valid_d = 1'b0;
            last_seen_d  = 1'b0;
            tail_built_d = 1'b0;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q        <= '0;
            asm_cnt_q    <= 4'd0;
            len_q        <= 8'd0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            last_seen_q  <= 1'b0;
            tail_built_q <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            asm_cnt_q    <= asm_cnt_d;
            len_q        <= len_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            last_seen_q  <= last_seen_d;
            tail_built_q <= tail_built_d;
        end
    end

    assign asm_full   = (asm_cnt_q == 4'd8);
    assign last_seen  = last_seen_q;
    assign tail_built = tail_built_q;
    assign pend_valid = pend_valid_q;
    assign pend_word  = pend_q;

endmodule

// File: rtl/siphash_msg_padder.sv
// SipHash message front end: packs a byte stream into 64-bit words, appends
// the length-byte padding and sequences siphash_core through
// initialize / compress per word / finalize.
//
//   state    | meaning
//   IDLE     | waiting for start
//   INIT     | core_initalize pulse
//   RUN      | accepting bytes, issuing one compress per pending word
//   FIN      | core_finalize pulse
//   WAIT_FIN | waiting for the core to finish finalization, then done
//
// The core lowers ready one cycle after taking a command, so ready is only
// trusted when the guard flag (set by any command pulse) is clear.
module siphash_msg_padder
    import siphash_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    input  logic              data_last,
    input  logic              msg_end,
    output logic              data_ready,
    input  logic              core_ready,
    output logic              core_initalize,
    output logic              core_compress,
    output logic              core_finalize,
    output logic [WORD_W-1:0] core_mi,
    output logic              busy,
    output logic              done
);

    logic [2:0] state_q, state_d;
    logic       busy_q, busy_d;
    logic       guard_q, guard_d;

    logic       clear_w;
    logic       init_w;
    logic       comp_w;
    logic       fin_w;
    logic       done_w;
    logic       core_free;
    logic       in_run;
    logic       ready_w;
    logic       accept_w;
    logic       set_last_w;

    logic              asm_full;
    logic              last_seen;
    logic              tail_built;
    logic              pend_valid;
    logic [WORD_W-1:0] pend_word;

    siphash_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear_w),
        .byte_accept (accept_w),
        .byte_in     (data_in),
        .set_last    (set_last_w),
        .pend_take   (comp_w),
        .asm_full    (asm_full),
        .last_seen   (last_seen),
        .tail_built  (tail_built),
        .pend_valid  (pend_valid),
        .pend_word   (pend_word)
    );

    // Byte handshake and end-of-message detection; msg_end only counts in RUN.
    always_comb begin
        in_run     = (state_q == ST_RUN);
        ready_w    = in_run && !last_seen && !asm_full;
        accept_w   = data_valid && ready_w;
        set_last_w = (accept_w && data_last) || (msg_end && in_run);
    end

    // Sequencer: state transitions and core command pulses.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        clear_w   = 1'b0;
        init_w    = 1'b0;
        comp_w    = 1'b0;
        fin_w     = 1'b0;
        done_w    = 1'b0;
        core_free = core_ready && !guard_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                    busy_d  = 1'b1;
                    clear_w = 1'b1;
                end
            end
            ST_INIT: begin
                init_w  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (pend_valid && core_free) begin
                    comp_w = 1'b1;
                end else if (tail_built && !pend_valid && core_free) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                fin_w   = 1'b1;
                state_d = ST_WAIT_FIN;
            end
            ST_WAIT_FIN: begin
                if (core_free) begin
                    done_w  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        guard_d = init_w || comp_w || fin_w;
    end

    // FSM, busy and guard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            guard_q <= guard_d;
        end
    end

    // Outputs are forced low while reset is held so nothing leaks before the first edge.
    always_comb begin
        data_ready     = ready_w && !reset;
        core_initalize = init_w && !reset;
        core_compress  = comp_w && !reset;
        core_finalize  = fin_w && !reset;
        core_mi        = (comp_w && !reset) ? pend_word : '0;
        busy           = busy_q && !reset;
        done           = done_w && !reset;
    end

endmodule

// File: tb/tb_siphash_msg_padder.sv
module tb_siphash_msg_padder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_last;
    logic        msg_end;
    logic        data_ready;
    logic        core_ready;
    logic        core_initalize;
    logic        core_compress;
    logic        core_finalize;
    logic [63:0] core_mi;
    logic        busy;
    logic        done;

    siphash_msg_padder dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_last      (data_last),
        .msg_end        (msg_end),
        .data_ready     (data_ready),
        .core_ready     (core_ready),
        .core_initalize (core_initalize),
        .core_compress  (core_compress),
        .core_finalize  (core_finalize),
        .core_mi        (core_mi),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core model: ready stays high for one cycle after a command, then drops for lat cycles.
    int   lat = 2;
    int   busy_cnt = 0;
    logic drop_pend = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            busy_cnt  <= 0;
            drop_pend <= 1'b0;
        end else if (core_compress || core_finalize) begin
            drop_pend <= 1'b1;
        end else if (drop_pend) begin
            drop_pend <= 1'b0;
            busy_cnt  <= lat;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign core_ready = (busy_cnt == 0);

    // Scoreboard: expected word sequence per message, built from the byte list.
    logic [63:0] exp_q[$];
    logic [63:0] got_log[$];
    int          done_cnt  = 0;
    int          stall_cnt = 0;
    bit          fin_seen  = 1'b0;
    bit          prev_cmd  = 1'b0;

    function automatic void model_push(input logic [7:0] b[$]);
        logic [63:0] w;
        int          n;
        n = b.size();
        w = '0;
        for (int i = 0; i < n; i++) begin
            w[8*(i%8) +: 8] = b[i];
            if (i % 8 == 7) begin
                exp_q.push_back(w);
                w = '0;
            end
        end
        w = w | (64'(n % 256) << 56);
        exp_q.push_back(w);
    endfunction

    // Per-cycle output checker.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_outs", {58'b0, data_ready, core_initalize, core_compress,
                                   core_finalize, busy, done}, 64'h0);
                chk("reset_mi", core_mi, 64'h0);
                exp_q.delete();
                fin_seen = 1'b0;
                prev_cmd = 1'b0;
            end else begin
                chk("pulse_onehot",
                    64'((32'(core_initalize) + 32'(core_compress) + 32'(core_finalize)) <= 1), 64'h1);
                if (!core_compress) chk("mi_idle_zero", core_mi, 64'h0);
                if (core_compress) begin
                    chk("cmp_core_free", 64'(core_ready && !prev_cmd), 64'h1);
                    got_log.push_back(core_mi);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL cmp_extra: got word %h expected none", core_mi);
                    end else begin
                        chk("cmp_word", core_mi, exp_q.pop_front());
                    end
                end
                if (core_finalize) begin
                    chk("fin_words_left", 64'(exp_q.size()), 64'h0);
                    fin_seen = 1'b1;
                end
                if (done) begin
                    chk("done_after_fin", 64'(fin_seen), 64'h1);
                    fin_seen = 1'b0;
                    done_cnt++;
                end
                if (data_valid && !data_ready && busy) stall_cnt++;
                prev_cmd = core_initalize || core_compress || core_finalize;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input int noise_at);
        int idx = 0;
        int budget = 0;
        while (idx < b.size() && budget < 5000) begin
            data_valid = 1'b1;
            data_in    = b[idx];
            data_last  = (idx == b.size() - 1);
            start      = (idx == noise_at);
            @(negedge clk);
            if (data_ready) idx++;
            @(posedge clk); #1;
            budget++;
        end
        data_valid = 1'b0;
        data_last  = 1'b0;
        start      = 1'b0;
        if (budget >= 5000) begin
            total++;
            bad++;
            $display("FAIL send_timeout: sent %0d of %0d bytes", idx, b.size());
        end
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        @(negedge clk);
        chk({name, "_done"}, 64'(done_cnt - d0), 64'h1);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'h0);
        chk({name, "_busy_low"}, 64'(busy), 64'h0);
        @(posedge clk); #1;
    endtask

    logic [7:0] msg[$];

    initial begin
        reset = 1'b1; start = 1'b0; data_in = 8'h0; data_valid = 1'b0;
        data_last = 1'b0; msg_end = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", 64'(busy), 64'h0);
        chk("post_reset_ready", 64'(data_ready), 64'h0);
        @(posedge clk); #1;

        // 15 bytes 00..0e
        msg.delete();
        for (int i = 0; i < 15; i++) msg.push_back(8'(i));
        got_log.delete();
        model_push(msg);
        chk("pin15_w0", exp_q[0], 64'h0706050403020100);
        chk("pin15_w1", exp_q[1], 64'h0f0e0d0c0b0a0908);
        pulse_start();
        @(negedge clk);
        chk("busy_after_start", 64'(busy), 64'h1);
        @(posedge clk); #1;
        send_bytes(msg, -1);
        wait_done("m15");
        chk("m15_count", 64'(got_log.size()), 64'd2);
        if (got_log.size() == 2) begin
            chk("m15_w0", got_log[0], 64'h0706050403020100);
            chk("m15_w1", got_log[1], 64'h0f0e0d0c0b0a0908);
        end

        // empty message via msg_end
        msg.delete();
        got_log.delete();
        model_push(msg);
        chk("pin_empty", exp_q[0], 64'h0);
        pulse_start();
        begin
            int c = 0;
            @(negedge clk);
            while (!data_ready && c < 100) begin
                @(negedge clk);
                c++;
            end
            chk("empty_ready_seen", 64'(data_ready), 64'h1);
        end
        @(posedge clk); #1 msg_end = 1'b1;
        @(posedge clk); #1 msg_end = 1'b0;
        wait_done("empty");
        chk("empty_count", 64'(got_log.size()), 64'd1);
        if (got_log.size() == 1) chk("empty_w0", got_log[0], 64'h0);

        // 8 bytes, plus a stray start mid-message that must be ignored
        msg.delete();
        for (int i = 0; i < 8; i++) msg.push_back(8'(i));
        got_log.delete();
        model_push(msg);
        chk("pin8_tail", exp_q[1], 64'h0800000000000000);
        pulse_start();
        send_bytes(msg, 3);
        wait_done("m8");
        chk("m8_count", 64'(got_log.size()), 64'd2);
        if (got_log.size() == 2) begin
            chk("m8_w0", got_log[0], 64'h0706050403020100);
            chk("m8_w1", got_log[1], 64'h0800000000000000);
        end

        // 256 bytes of aa: length wraps to zero
        msg.delete();
        for (int i = 0; i < 256; i++) msg.push_back(8'haa);
        got_log.delete();
        model_push(msg);
        chk("pin256_size", 64'(exp_q.size()), 64'd33);
        chk("pin256_tail", exp_q[32], 64'h0);
        pulse_start();
        send_bytes(msg, -1);
        wait_done("m256");
        chk("m256_count", 64'(got_log.size()), 64'd33);
        if (got_log.size() == 33) begin
            chk("m256_w31", got_log[31], 64'haaaaaaaaaaaaaaaa);
            chk("m256_tail", got_log[32], 64'h0);
        end

        // slow core: back-pressure on the byte stream
        lat = 20;
        stall_cnt = 0;
        msg.delete();
        for (int i = 0; i < 40; i++) msg.push_back(8'(i * 3 + 1));
        got_log.delete();
        model_push(msg);
        pulse_start();
        send_bytes(msg, -1);
        wait_done("slow");
        chk("slow_stalled", 64'(stall_cnt > 0), 64'h1);
        chk("slow_count", 64'(got_log.size()), 64'd6);
        lat = 2;

        // reset mid-message, then a short message
        msg.delete();
        for (int i = 0; i < 10; i++) msg.push_back(8'(8'h50 + i));
        got_log.delete();
        model_push(msg);
        pulse_start();
        send_bytes(msg, -1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        msg.delete();
        for (int i = 1; i <= 3; i++) msg.push_back(8'(i));
        got_log.delete();
        model_push(msg);
        chk("pin3_w0", exp_q[0], 64'h0300000000030201);
        pulse_start();
        send_bytes(msg, -1);
        wait_done("m3");
        chk("m3_count", 64'(got_log.size()), 64'd1);
        if (got_log.size() == 1) chk("m3_w0", got_log[0], 64'h0300000000030201);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
